// File: rtl/axi2apb_bridge.sv
// axi2apb_bridge: AXI4-Lite to APB4 bridge, one transfer in flight, decoding SLV_NUM
// windows above SLV_BASE, with write/read alternation and an optional ACCESS timeout.
`default_nettype none
module axi2apb_bridge #(
  parameter int          SLV_NUM  = 4,
  parameter int          SLV_ADRW = 12,
  parameter logic [31:0] SLV_BASE = 32'h80000000,
  parameter int          DATA_W   = 32,
  parameter int          TIMEOUT  = 256
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              awaddr,
  input  logic                     wvalid,
  output logic                     wready,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [DATA_W/8-1:0]      wstrb,
  output logic                     bvalid,
  input  logic                     bready,
  output logic [1:0]               bresp,
  input  logic                     arvalid,
  output logic                     arready,
  input  logic [31:0]              araddr,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [DATA_W-1:0]        rdata,
  output logic [1:0]               rresp,
  output logic [SLV_NUM-1:0]       psel,
  output logic                     penable,
  output logic                     pwrite,
  output logic [SLV_ADRW-1:0]      paddr,
  output logic [DATA_W-1:0]        pwdata,
  output logic [DATA_W/8-1:0]      pstrb,
  input  logic [SLV_NUM-1:0]       pready,
  input  logic [SLV_NUM*DATA_W-1:0] prdata,
  input  logic [SLV_NUM-1:0]       pslverr
);

  localparam int          IDXW     = (SLV_NUM > 1) ? $clog2(SLV_NUM) : 1;
  localparam int          CNTW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [31:0] DEC_MASK = 32'hFFFFFFFF << (SLV_ADRW + IDXW);

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, BRESP, RDATA} state_t;

  state_t              state, state_nxt;
  logic                last_wr;
  logic [IDXW-1:0]     idx;
  logic [CNTW-1:0]     tcnt;
  logic [1:0]          resp;
  logic [DATA_W-1:0]   rdata_q;

  logic                wr_win, rd_win, acc_hit, tmo;
  logic [31:0]         acc_addr;
  logic [IDXW-1:0]     acc_idx;
  logic                sel_ready, sel_err;
  logic [DATA_W-1:0]   sel_rdata;

  always_comb begin
    // Write wins a tie unless it was the last direction served.
    wr_win   = (state == IDLE) && !areset && awvalid && wvalid && (!arvalid || !last_wr);
    rd_win   = (state == IDLE) && !areset && arvalid && !wr_win;
    acc_addr = wr_win ? awaddr : araddr;
    acc_idx  = acc_addr[SLV_ADRW +: IDXW];
    acc_hit  = (((acc_addr ^ SLV_BASE) & DEC_MASK) == 32'h0) &&
               ({{(32-IDXW){1'b0}}, acc_idx} < 32'(SLV_NUM));
    tmo      = (TIMEOUT > 0) && (tcnt == CNTW'(TIMEOUT - 1));

    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    psel      = '0;
    for (int s = 0; s < SLV_NUM; s++) begin
      if (idx == IDXW'(s)) begin
        sel_ready = pready[s];
        sel_err   = pslverr[s];
        sel_rdata = prdata[s*DATA_W +: DATA_W];
        psel[s]   = (state == SETUP) || (state == ACCESS);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    awready   = wr_win;
    wready    = wr_win;
    arready   = rd_win;
    bvalid    = (state == BRESP);
    rvalid    = (state == RDATA);
    penable   = (state == ACCESS);
    bresp     = resp;
    rresp     = resp;
    rdata     = rdata_q;
    case (state)
      IDLE: begin
        if (wr_win || rd_win)
          state_nxt = acc_hit ? SETUP : (wr_win ? BRESP : RDATA);
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (sel_ready || tmo)
          state_nxt = pwrite ? BRESP : RDATA;
      end
      BRESP:  if (bready) state_nxt = IDLE;
      RDATA:  if (rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      last_wr <= 1'b0;
      idx     <= '0;
      tcnt    <= '0;
      resp    <= 2'b00;
      rdata_q <= '0;
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      pwrite  <= 1'b0;
    end else begin
      if (wr_win || rd_win) begin
        last_wr <= wr_win;
        tcnt    <= '0;
        // APB-facing registers change only when an APB cycle will follow.
        if (acc_hit) begin
          idx    <= acc_idx;
          paddr  <= acc_addr[SLV_ADRW-1:0];
          pwrite <= wr_win;
          pstrb  <= wr_win ? wstrb : '0;
          if (wr_win) pwdata <= wdata;
        end else begin
          resp    <= 2'b11;
          rdata_q <= '0;
        end
      end
      if (state == ACCESS) begin
        if (sel_ready) begin
          resp <= sel_err ? 2'b10 : 2'b00;
          if (!pwrite) rdata_q <= sel_rdata;
        end else if (tmo) begin
          resp    <= 2'b10;
          rdata_q <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi2apb_bridge.sv
// tb_axi2apb_bridge: scoreboard bench with a randomised APB completer model for axi2apb_bridge.
`default_nettype none
module tb_axi2apb_bridge;
  localparam int          N    = 4;
  localparam int          AW   = 12;
  localparam int          DW   = 32;
  localparam int          TMO  = 8;
  localparam logic [31:0] BASE = 32'h80000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          areset;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0]   awaddr, araddr;
  logic [DW-1:0] wdata, rdata, pwdata;
  logic [3:0]    wstrb, pstrb;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready;
  logic [N-1:0]  psel, pready, pslverr;
  logic          penable, pwrite;
  logic [AW-1:0] paddr;
  logic [N*DW-1:0] prdata;

  axi2apb_bridge #(.SLV_NUM(N), .SLV_ADRW(AW), .SLV_BASE(BASE), .DATA_W(DW), .TIMEOUT(TMO)) dut (
    .aclk(clk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  typedef struct { bit wr; logic [1:0] resp; logic [31:0] data; } exp_t;
  typedef struct {
    logic [N-1:0] sel; int idx; logic [AW-1:0] addr; bit wr;
    logic [31:0] wdata; logic [3:0] strb; int wt; bit err; logic [31:0] rd;
  } apb_t;

  exp_t sb_q[$];
  apb_t apb_q[$];
  int   checks = 0;
  int   passed = 0;
  bit   last_wr = 1'b0;

  task automatic check(string name, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic fail(string name);
    checks++;
    $display("FAIL %s: got bound expired required event", name);
  endtask

  // Reference model: decode by address range, completer outcome by its wait count.
  task automatic plan(bit wr, logic [31:0] addr, logic [31:0] wd, logic [3:0] st,
                      int wt, bit err, logic [31:0] rd);
    exp_t   e;
    apb_t   a;
    longint off;
    bit     hit;
    off = longint'(addr) - longint'(BASE);
    hit = (off >= 0) && (off < (longint'(N) << AW));
    e.wr = wr;
    if (!hit)          begin e.resp = 2'b11; e.data = 32'h0; end
    else if (wt >= TMO) begin e.resp = 2'b10; e.data = 32'h0; end
    else               begin e.resp = err ? 2'b10 : 2'b00; e.data = rd; end
    if (hit) begin
      a.idx   = int'(off >> AW);
      a.sel   = N'(1 << a.idx);
      a.addr  = addr[AW-1:0];
      a.wr    = wr;
      a.wdata = wd;
      a.strb  = wr ? st : 4'h0;
      a.wt    = wt;
      a.err   = err;
      a.rd    = rd;
      apb_q.push_back(a);
    end
    sb_q.push_back(e);
    last_wr = wr;
  endtask

  task automatic send_write(logic [31:0] addr, logic [31:0] wd, logic [3:0] st);
    bit got = 1'b0;
    awaddr = addr; wdata = wd; wstrb = st; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (awready) begin got = 1'b1; check("w_ready_pair", wready, 1'b1); end
    end
    if (!got) fail("aw_accept");
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
  endtask

  task automatic send_read(logic [31:0] addr);
    bit got = 1'b0;
    araddr = addr; arvalid = 1'b1;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (arready) got = 1'b1;
    end
    if (!got) fail("ar_accept");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 2000 && (sb_q.size() != 0 || apb_q.size() != 0); i++) @(negedge clk);
    if (i == 2000) fail("drain");
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(string name);
    check(name, {awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp,
                 psel, penable, pwrite, paddr, pwdata, pstrb}, 128'h0);
  endtask

  // Response ready pressure.
  initial begin
    bready = 1'b0; rready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bready = ($urandom_range(0, 3) != 0);
      rready = ($urandom_range(0, 3) != 0);
    end
  end

  // APB completer model and protocol checker.
  initial begin
    apb_t cur;
    int   acc;
    bit   active;
    active = 1'b0; acc = 0;
    pready = '0; pslverr = '0; prdata = '0;
    forever begin
      @(negedge clk);
      if (areset) begin
        active = 1'b0; pready = '0; pslverr = '0;
      end else if (psel == '0) begin
        if (active) check("access_len", acc, (cur.wt >= TMO) ? TMO : cur.wt + 1);
        active = 1'b0; pready = '0; pslverr = '0;
      end else if (!penable) begin
        if (apb_q.size() == 0) begin
          fail("unexpected_psel");
          active = 1'b0;
        end else begin
          cur = apb_q.pop_front();
          check("setup", {psel, paddr, pwrite, pstrb}, {cur.sel, cur.addr, cur.wr, cur.strb});
          if (cur.wr) check("setup_pwdata", pwdata, cur.wdata);
          active = 1'b1;
        end
        acc = 0; pready = '0;
      end else if (active) begin
        check("access_stable", {psel, paddr, pwrite, pstrb}, {cur.sel, cur.addr, cur.wr, cur.strb});
        if (cur.wr) check("access_pwdata", pwdata, cur.wdata);
        pready  = N'($urandom) & ~cur.sel;
        pslverr = N'($urandom) & ~cur.sel;
        for (int s = 0; s < N; s++) prdata[s*DW +: DW] = $urandom;
        if (acc == cur.wt) begin
          pready  = pready | cur.sel;
          pslverr = cur.err ? (pslverr | cur.sel) : (pslverr & ~cur.sel);
          prdata[cur.idx*DW +: DW] = cur.rd;
        end
        acc++;
      end
    end
  end

  // Response monitor / scoreboard.
  initial begin
    exp_t e;
    bit bh, rh;
    logic [1:0] bp;
    logic [33:0] rp;
    bh = 1'b0; rh = 1'b0; bp = 2'b0; rp = '0;
    forever begin
      @(negedge clk);
      if (areset) begin
        bh = 1'b0; rh = 1'b0;
      end else begin
        if (bh) check("b_hold", {bvalid, bresp}, {1'b1, bp});
        if (rh) check("r_hold", {rvalid, rresp, rdata}, {1'b1, rp});
        if (bvalid && bready) begin
          if (sb_q.size() == 0) fail("unexpected_b");
          else begin
            e = sb_q.pop_front();
            check("b_order", 1'b1, e.wr);
            check("bresp", bresp, e.resp);
          end
        end
        if (rvalid && rready) begin
          if (sb_q.size() == 0) fail("unexpected_r");
          else begin
            e = sb_q.pop_front();
            check("r_order", 1'b0, e.wr);
            check("rresp_rdata", {rresp, rdata}, {e.resp, e.data});
          end
        end
        bh = bvalid && !bready; bp = bresp;
        rh = rvalid && !rready; rp = {rresp, rdata};
      end
    end
  end

  initial begin
    logic [31:0] wa[2], wd[2], ra[2], rd[2];
    logic [3:0]  ws[2];
    int          wt[4], nw, nr, k, i;
    bit          seen;
    logic [31:0] addr;

    areset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    awaddr = '0; araddr = '0; wdata = '0; wstrb = '0;
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    @(negedge clk);
    check_all_zero("reset_outputs");
    @(posedge clk); #1;

    // Directed: write with two wait cycles, errored read, decode miss.
    plan(1'b1, 32'h80001004, 32'hA5A5A5A5, 4'hF, 2, 1'b0, 32'h0);
    send_write(32'h80001004, 32'hA5A5A5A5, 4'hF);
    wait_idle();
    plan(1'b0, 32'h80003008, 32'h0, 4'h0, 1, 1'b1, 32'h12345678);
    send_read(32'h80003008);
    wait_idle();
    plan(1'b0, 32'h90000000, 32'h0, 4'h0, 0, 1'b0, 32'hDEADBEEF);
    send_read(32'h90000000);
    wait_idle();

    // Window boundaries.
    plan(1'b0, BASE + 32'h3FFC, 32'h0, 4'h0, 0, 1'b0, 32'hCAFEF00D);
    send_read(BASE + 32'h3FFC);
    plan(1'b1, BASE + 32'h4000, 32'h11223344, 4'h3, 0, 1'b0, 32'h0);
    send_write(BASE + 32'h4000, 32'h11223344, 4'h3);
    plan(1'b0, BASE - 32'h4, 32'h0, 4'h0, 0, 1'b0, 32'h55555555);
    send_read(BASE - 32'h4);
    wait_idle();

    // All three valids held: order follows the alternation rule.
    for (int j = 0; j < 2; j++) begin
      wa[j] = BASE + 32'($urandom_range(0, N*4096 - 1));
      ra[j] = BASE + 32'($urandom_range(0, N*4096 - 1));
      wd[j] = $urandom; rd[j] = $urandom; ws[j] = 4'($urandom);
    end
    for (int j = 0; j < 4; j++) wt[j] = $urandom_range(0, 3);
    nw = 0; nr = 0;
    for (k = 0; k < 4; k++) begin
      if (nw < 2 && (nr == 2 || !last_wr)) begin
        plan(1'b1, wa[nw], wd[nw], ws[nw], wt[k], 1'b0, 32'h0); nw++;
      end else begin
        plan(1'b0, ra[nr], 32'h0, 4'h0, wt[k], 1'b0, rd[nr]); nr++;
      end
    end
    fork
      begin for (int j = 0; j < 2; j++) send_write(wa[j], wd[j], ws[j]); end
      begin for (int j = 0; j < 2; j++) send_read(ra[j]); end
    join
    wait_idle();

    // Timeout, then a normal transfer.
    plan(1'b1, 32'h80002010, 32'h0BADF00D, 4'hF, 100, 1'b0, 32'h0);
    send_write(32'h80002010, 32'h0BADF00D, 4'hF);
    plan(1'b1, 32'h80002014, 32'h600DF00D, 4'hC, 1, 1'b0, 32'h0);
    send_write(32'h80002014, 32'h600DF00D, 4'hC);
    wait_idle();

    // Randomised traffic.
    for (int n = 0; n < 40; n++) begin
      addr = ($urandom_range(0, 9) < 8) ? BASE + 32'($urandom_range(0, N*4096 - 1)) : $urandom;
      k = ($urandom_range(0, 9) == 0) ? TMO + $urandom_range(0, 3) : $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        wd[0] = $urandom; ws[0] = 4'($urandom);
        plan(1'b1, addr, wd[0], ws[0], k, 1'($urandom), 32'h0);
        send_write(addr, wd[0], ws[0]);
      end else begin
        plan(1'b0, addr, 32'h0, 4'h0, k, 1'($urandom), $urandom);
        send_read(addr);
      end
    end
    wait_idle();

    // Reset in the middle of ACCESS, then a fresh read.
    plan(1'b0, 32'h80001100, 32'h0, 4'h0, 100, 1'b0, 32'h0);
    send_read(32'h80001100);
    seen = 1'b0;
    for (i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (penable) seen = 1'b1;
    end
    check("reached_access", seen, 1'b1);
    @(posedge clk); #1 areset = 1'b1;
    @(posedge clk); #1 areset = 1'b0;
    sb_q.delete(); apb_q.delete(); last_wr = 1'b0;
    @(negedge clk);
    check_all_zero("mid_access_reset");
    @(posedge clk); #1;
    plan(1'b0, 32'h80000020, 32'h0, 4'h0, 1, 1'b0, 32'h87654321);
    send_read(32'h80000020);
    wait_idle();

    check("queues_drained", {32'(sb_q.size()), 32'(apb_q.size())}, 64'h0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: got timeout required completion");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/axi2apb_bridge.md
AXI2APB_BRIDGE -- requirements
Module: axi2apb_bridge

Interface
REQ-001 SHALL have parameter SLV_NUM, default 4: number of APB completers, 1..16.
REQ-002 SHALL have parameter SLV_ADRW, default 12: per-completer address bits (window = 2^SLV_ADRW bytes).
REQ-003 SHALL have parameter SLV_BASE, default 32'h80000000: base of the decoded region.
REQ-004 SHALL have parameter DATA_W, default 32: data width, one of 8/16/32.
REQ-005 SHALL have parameter TIMEOUT, default 256: ACCESS-phase wait limit in cycles; 0 disables it.
REQ-006 SHALL have port aclk  in  1  clock.
REQ-007 SHALL have port areset  in  1  synchronous, active-high reset.
REQ-008 SHALL have port awvalid  in  1  AXI-Lite write-address valid.
REQ-009 SHALL have port awready  out  1  write-address accept.
REQ-010 SHALL have port awaddr  in  32  write address.
REQ-011 SHALL have port wvalid  in  1  write-data valid.
REQ-012 SHALL have port wready  out  1  write-data accept.
REQ-013 SHALL have port wdata  in  DATA_W  write data.
REQ-014 SHALL have port wstrb  in  DATA_W/8  byte strobes.
REQ-015 SHALL have port bvalid  out  1  write-response valid.
REQ-016 SHALL have port bready  in  1  write-response accept.
REQ-017 SHALL have port bresp  out  2  write response.
REQ-018 SHALL have port arvalid  in  1  read-address valid.
REQ-019 SHALL have port arready  out  1  read-address accept.
REQ-020 SHALL have port araddr  in  32  read address.
REQ-021 SHALL have port rvalid  out  1  read-data valid.
REQ-022 SHALL have port rready  in  1  read-data accept.
REQ-023 SHALL have port rdata  out  DATA_W  read data.
REQ-024 SHALL have port rresp  out  2  read response.
REQ-025 SHALL have port psel  out  SLV_NUM  one-hot completer select.
REQ-026 SHALL have port penable  out  1  APB ACCESS phase.
REQ-027 SHALL have port pwrite  out  1  APB direction, 1 = write.
REQ-028 SHALL have port paddr  out  SLV_ADRW  offset within the window.
REQ-029 SHALL have port pwdata  out  DATA_W  APB write data.
REQ-030 SHALL have port pstrb  out  DATA_W/8  APB4 strobes; 0 on reads.
REQ-031 SHALL have port pready  in  SLV_NUM  per-completer ready.
REQ-032 SHALL have port prdata  in  SLV_NUM*DATA_W  per-completer read data; completer s occupies bits [s*DATA_W +: DATA_W].
REQ-033 SHALL have port pslverr  in  SLV_NUM  per-completer error.

Function
REQ-034 SHALL implement the FSM IDLE, SETUP, ACCESS, BRESP, RDATA; one transaction is in flight at a time.
REQ-035 Acceptance from IDLE SHALL behave as follows:
- write candidate = awvalid & wvalid; read candidate = arvalid.
- If both are candidates, the direction not served last wins; the first arbitration after reset favours write.
- Write win: awready and wready pulse together for 1 cycle; awaddr, wdata and wstrb are registered.
- Read win: arready pulses for 1 cycle; araddr is registered.
REQ-036 Decode SHALL hit when ((addr^SLV_BASE) & (32'hFFFFFFFF << (SLV_ADRW+IDXW))) == 0 and idx < SLV_NUM, where idx = addr[SLV_ADRW +: IDXW] and IDXW = max(1, clog2(SLV_NUM)).
- Hit: next state SETUP.
- Miss: no APB cycle, psel stays 0; next state BRESP or RDATA with resp 2'b11 (DECERR) and rdata 0.
REQ-037 SETUP SHALL last exactly 1 cycle with psel[idx]=1, penable=0 and paddr/pwrite/pwdata/pstrb driven from the captured registers; the state then goes to ACCESS.
REQ-038 ACCESS SHALL hold psel[idx]=1 and penable=1 with all APB outputs stable until pready[idx]=1.
- On that cycle: capture prdata[idx] (reads) and set resp = pslverr[idx] ? 2'b10 : 2'b00.
- Next state BRESP or RDATA.
REQ-039 ACCESS timeout: when TIMEOUT>0 and pready[idx] stays 0 for TIMEOUT consecutive ACCESS cycles:
- deassert psel/penable;
- resp = 2'b10, rdata = 0;
- go to BRESP/RDATA.
The counter SHALL clear on entry to SETUP.
REQ-040 bvalid (in BRESP) and rvalid (in RDATA) SHALL hold with stable bresp/rresp/rdata until bready/rready; the bridge then returns to IDLE, and the next acceptance is no earlier than the following cycle.
REQ-041 Outside SETUP/ACCESS: psel=0 and penable=0; paddr, pwdata and pstrb hold their last values.
REQ-042 Responses SHALL NOT be reordered or dropped; exactly one B per accepted AW+W and one R per accepted AR.

Reset
REQ-043 While areset=1 at a clock edge, the bridge SHALL, from the next cycle:
- enter IDLE, abandoning any in-flight transfer including mid-ACCESS;
- drive all valid/ready/psel/penable/pwrite outputs 0 and all data/addr/resp/pstrb outputs 0;
- clear the timeout counter and set the arbitration flag to favour write.

Verification
REQ-044 Write 32'h80001004 data 32'hA5A5A5A5 strb 4'hF, SLV_NUM=4, completer 1 pready after 2 wait cycles -> psel=4'b0010 SETUP 1 cycle then ACCESS 3 cycles, pstrb=4'hF, bresp=2'b00.
REQ-045 Read 32'h80003008, completer 3 returns 32'h12345678 with pslverr=1 -> rdata=32'h12345678, rresp=2'b10.
REQ-046 Read 32'h90000000 (decode miss) -> psel never asserted, rvalid with rresp=2'b11 and rdata=0.
REQ-047 awvalid, wvalid and arvalid all held high for 4 transactions -> order W,R,W,R, each with the correct response.
REQ-048 TIMEOUT=8, pready held 0 -> psel drops after 8 ACCESS cycles, bresp=2'b10; a subsequent transfer completes normally.
REQ-049 areset pulsed mid-ACCESS -> next cycle all outputs 0, state IDLE; a fresh read then succeeds.
